// File: rtl/clk_divider_multi_if.sv
// clk_divider_multi_if: shadow-register write port of the multi-channel clock divider
interface clk_divider_multi_if #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
);
    logic             wr_en;
    logic [CH_W-1:0]  wr_chan;
    logic [WIDTH-1:0] wr_div;
    logic             wr_mode;

    modport master (output wr_en, wr_chan, wr_div, wr_mode);
    modport slave  (input  wr_en, wr_chan, wr_div, wr_mode);
endinterface

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: per-channel programmable divider (toggle or pulse) with glitch-free double-buffered reprogramming
module clk_divider_multi #(
    parameter int          WIDTH       = 32,
    parameter int          CHANNELS    = 4,
    parameter int          CH_W        = 2,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic                inclk,
    input  logic                Reset,
    clk_divider_multi_if.slave  wr,
    input  logic [CHANNELS-1:0] ch_enable,
    input  logic                sync_restart,
    output logic [CHANNELS-1:0] outclk,
    output logic [CHANNELS-1:0] outclk_Not,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);
    logic [WIDTH-1:0]    cnt     [CHANNELS];
    logic [WIDTH-1:0]    act_div [CHANNELS];
    logic [WIDTH-1:0]    sh_div  [CHANNELS];
    logic [WIDTH-1:0]    cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] act_mode, sh_mode, apply, out_nxt, tick_nxt;

    assign outclk_Not = ~outclk;

    // terminal detection (one extra bit so the increment never wraps) and next counter/output per channel
    always_comb begin
        logic [WIDTH:0]   inc;
        logic [WIDTH-1:0] eff;
        logic             h, t;
        inc = '0;
        eff = '0;
        h = 1'b0;
        t = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            eff = (act_div[i] == '0) ? WIDTH'(1) : act_div[i];
            inc = {1'b0, cnt[i]} + (WIDTH+1)'(1);
            t = inc >= {1'b0, eff};
            h = sync_restart || !ch_enable[i];
            apply[i] = h || t;
            cnt_nxt[i] = (h || t) ? '0 : inc[WIDTH-1:0];
            tick_nxt[i] = !h && t;
            out_nxt[i] = h ? 1'b0
                       : t ? (sh_mode[i] == act_mode[i]) && (act_mode[i] || !outclk[i])
                       : !act_mode[i] && outclk[i];
        end
    end

    // state update: the pre-write shadow is applied first, so a same-cycle write stays pending
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]     <= '0;
                act_div[i] <= WIDTH'(DEFAULT_DIV);
                sh_div[i]  <= WIDTH'(DEFAULT_DIV);
            end
            act_mode <= '0;
            sh_mode  <= '0;
            outclk   <= '0;
            tick     <= '0;
            pending  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (apply[i]) begin
                    act_div[i]  <= sh_div[i];
                    act_mode[i] <= sh_mode[i];
                    pending[i]  <= 1'b0;
                end
                if (wr.wr_en && wr.wr_chan == CH_W'(i)) begin
                    sh_div[i]  <= wr.wr_div;
                    sh_mode[i] <= wr.wr_mode;
                    pending[i] <= 1'b1;
                end
            end
            outclk <= out_nxt;
            tick   <= tick_nxt;
        end
    end
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: directed scenarios with an edge-indexed expectation scoreboard
module tb_clk_divider_multi;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int CW = 2;

    logic         inclk = 1'b0;
    logic         Reset = 1'b0;
    logic [N-1:0] ch_enable = '0;
    logic         sync_restart = 1'b0;
    logic [N-1:0] outclk, outclk_Not, tick, pending;

    clk_divider_multi_if #(.WIDTH(W), .CH_W(CW)) wr ();

    clk_divider_multi #(.WIDTH(W), .CHANNELS(N), .CH_W(CW), .DEFAULT_DIV(4)) dut (
        .inclk(inclk),
        .Reset(Reset),
        .wr(wr),
        .ch_enable(ch_enable),
        .sync_restart(sync_restart),
        .outclk(outclk),
        .outclk_Not(outclk_Not),
        .tick(tick),
        .pending(pending)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        int           e;
        logic [N-1:0] m;
        logic [N-1:0] oc;
        logic [N-1:0] tk;
        logic [N-1:0] pd;
        string        tag;
    } chk_t;

    chk_t q[$];
    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int org = 0;

    always @(posedge inclk) edge_n <= edge_n + 1;

    task automatic ex(int k, logic [N-1:0] m, logic [N-1:0] oc, logic [N-1:0] tk, logic [N-1:0] pd, string tag);
        q.push_back('{org + k, m, oc, tk, pd, tag});
    endtask

    task automatic at(int k);
        while (edge_n < org + k) begin
            @(posedge inclk);
            #1;
        end
    endtask

    task automatic wr_do(logic [CW-1:0] c, logic [W-1:0] d, logic md);
        wr.wr_en = 1'b1;
        wr.wr_chan = c;
        wr.wr_div = d;
        wr.wr_mode = md;
        @(posedge inclk);
        #1;
        wr.wr_en = 1'b0;
    endtask

    task automatic cmp(string tag, string what, logic [N-1:0] got, logic [N-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s edge=%0d got=%b want=%b", tag, what, edge_n, got, want);
        end
    endtask

    // monitor: compare every expectation due at the edge just taken
    always @(negedge inclk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].e < edge_n) begin
                total++;
                bad++;
                $display("FAIL %s missed at edge %0d (now %0d)", q[i].tag, q[i].e, edge_n);
                q.delete(i);
            end else if (q[i].e == edge_n) begin
                cmp(q[i].tag, "outclk", outclk & q[i].m, q[i].oc & q[i].m);
                cmp(q[i].tag, "tick", tick & q[i].m, q[i].tk & q[i].m);
                cmp(q[i].tag, "pending", pending & q[i].m, q[i].pd & q[i].m);
                cmp(q[i].tag, "outclk_Not", outclk_Not & q[i].m, ~q[i].oc & q[i].m);
                q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        wr.wr_en = 1'b0;
        wr.wr_chan = '0;
        wr.wr_div = '0;
        wr.wr_mode = 1'b0;
        repeat (2) @(posedge inclk);
        #1;
        org = edge_n;
        ex(0, 3'b111, 3'b000, 3'b000, 3'b000, "in_reset");
        @(posedge inclk);
        #1;
        Reset = 1'b1;
        ch_enable = 3'b001;
        org = edge_n;
        // toggle mode, default divisor 4, only ch0 enabled
        ex(0,  3'b111, 3'b000, 3'b000, 3'b000, "a_e0");
        ex(3,  3'b111, 3'b000, 3'b000, 3'b000, "a_e3");
        ex(4,  3'b111, 3'b001, 3'b001, 3'b000, "a_e4");
        ex(5,  3'b111, 3'b001, 3'b000, 3'b000, "a_e5");
        ex(7,  3'b111, 3'b001, 3'b000, 3'b000, "a_e7");
        ex(8,  3'b111, 3'b000, 3'b001, 3'b000, "a_e8");
        ex(12, 3'b111, 3'b001, 3'b001, 3'b000, "a_e12");
        // divisor change with an overwritten shadow
        ex(14, 3'b001, 3'b001, 3'b000, 3'b001, "b_e14");
        ex(15, 3'b001, 3'b001, 3'b000, 3'b001, "b_e15");
        ex(16, 3'b001, 3'b000, 3'b001, 3'b000, "b_e16");
        ex(17, 3'b001, 3'b000, 3'b000, 3'b000, "b_e17");
        ex(18, 3'b001, 3'b001, 3'b001, 3'b000, "b_e18");
        ex(20, 3'b001, 3'b000, 3'b001, 3'b000, "b_e20");
        // pulse mode on ch1, written while disabled
        ex(21, 3'b010, 3'b000, 3'b000, 3'b010, "c_e21");
        ex(22, 3'b010, 3'b000, 3'b000, 3'b000, "c_e22");
        ex(24, 3'b010, 3'b000, 3'b000, 3'b000, "c_e24");
        ex(25, 3'b010, 3'b010, 3'b010, 3'b000, "c_e25");
        ex(26, 3'b010, 3'b000, 3'b000, 3'b000, "c_e26");
        ex(28, 3'b010, 3'b010, 3'b010, 3'b000, "c_e28");
        ex(31, 3'b010, 3'b010, 3'b010, 3'b000, "c_e31");
        at(13);
        wr_do(2'd0, 8'd7, 1'b0);
        wr_do(2'd0, 8'd2, 1'b0);
        at(20);
        wr_do(2'd1, 8'd3, 1'b1);
        at(22);
        ch_enable = 3'b011;
        at(32);

        // boundary divisors on ch2: 0, 1, 255
        org = edge_n;
        ex(1,   3'b100, 3'b000, 3'b000, 3'b100, "d_e1");
        ex(2,   3'b100, 3'b000, 3'b000, 3'b000, "d_e2");
        ex(3,   3'b100, 3'b100, 3'b100, 3'b000, "d_e3");
        ex(4,   3'b100, 3'b000, 3'b100, 3'b000, "d_e4");
        ex(5,   3'b100, 3'b100, 3'b100, 3'b000, "d_e5");
        ex(6,   3'b100, 3'b000, 3'b100, 3'b100, "d_e6");
        ex(7,   3'b100, 3'b100, 3'b100, 3'b000, "d_e7");
        ex(8,   3'b100, 3'b000, 3'b100, 3'b000, "d_e8");
        ex(9,   3'b100, 3'b100, 3'b100, 3'b100, "d_e9");
        ex(10,  3'b100, 3'b000, 3'b100, 3'b000, "d_e10");
        ex(11,  3'b100, 3'b000, 3'b000, 3'b000, "d_e11");
        ex(264, 3'b100, 3'b000, 3'b000, 3'b000, "d_e264");
        ex(265, 3'b100, 3'b100, 3'b100, 3'b000, "d_e265");
        ex(266, 3'b100, 3'b100, 3'b000, 3'b000, "d_e266");
        ex(519, 3'b100, 3'b100, 3'b000, 3'b000, "d_e519");
        ex(520, 3'b100, 3'b000, 3'b100, 3'b000, "d_e520");
        wr_do(2'd2, 8'd0, 1'b0);
        at(2);
        ch_enable = 3'b111;
        at(5);
        wr_do(2'd2, 8'd1, 1'b0);
        at(8);
        wr_do(2'd2, 8'd255, 1'b0);
        at(521);

        // sync_restart, mode change at terminal, write on terminal edge, out-of-range channel
        org = edge_n;
        ex(1,  3'b111, 3'b000, 3'b000, 3'b000, "e_e1");
        ex(2,  3'b111, 3'b000, 3'b000, 3'b001, "e_e2");
        ex(3,  3'b111, 3'b001, 3'b001, 3'b010, "e_e3");
        ex(4,  3'b111, 3'b000, 3'b000, 3'b000, "e_restart");
        ex(6,  3'b111, 3'b000, 3'b000, 3'b000, "e_e6");
        ex(7,  3'b111, 3'b001, 3'b001, 3'b000, "e_e7");
        ex(9,  3'b111, 3'b011, 3'b010, 3'b000, "e_e9");
        ex(10, 3'b111, 3'b010, 3'b001, 3'b000, "e_e10");
        ex(17, 3'b010, 3'b000, 3'b000, 3'b010, "e_mode_pend");
        ex(19, 3'b010, 3'b000, 3'b010, 3'b000, "e_mode_apply");
        ex(24, 3'b010, 3'b010, 3'b010, 3'b000, "e_pulse24");
        ex(25, 3'b010, 3'b000, 3'b000, 3'b000, "e_pulse25");
        ex(22, 3'b001, 3'b000, 3'b001, 3'b001, "e_wr_on_term");
        ex(24, 3'b001, 3'b000, 3'b000, 3'b001, "e_old_div");
        ex(25, 3'b001, 3'b001, 3'b001, 3'b000, "e_new_apply");
        ex(26, 3'b001, 3'b001, 3'b000, 3'b000, "e_e26");
        ex(27, 3'b001, 3'b000, 3'b001, 3'b000, "e_e27");
        ex(28, 3'b111, 3'b000, 3'b000, 3'b000, "e_bad_chan");
        ex(29, 3'b111, 3'b011, 3'b011, 3'b000, "e_e29");
        sync_restart = 1'b1;
        @(posedge inclk);
        #1;
        sync_restart = 1'b0;
        wr_do(2'd0, 8'd3, 1'b0);
        wr_do(2'd1, 8'd5, 1'b0);
        sync_restart = 1'b1;
        @(posedge inclk);
        #1;
        sync_restart = 1'b0;
        at(15);
        wr_do(2'd1, 8'd5, 1'b1);
        at(21);
        wr_do(2'd0, 8'd2, 1'b0);
        at(27);
        wr_do(2'd3, 8'd9, 1'b1);
        at(30);

        // enable drop/re-enable on ch2, then asynchronous reset
        org = edge_n;
        ex(1,  3'b100, 3'b000, 3'b000, 3'b100, "f_e1");
        ex(2,  3'b100, 3'b000, 3'b000, 3'b000, "f_e2");
        ex(5,  3'b100, 3'b100, 3'b100, 3'b000, "f_e5");
        ex(6,  3'b100, 3'b100, 3'b000, 3'b000, "f_e6");
        ex(7,  3'b100, 3'b000, 3'b000, 3'b000, "f_disable");
        ex(10, 3'b100, 3'b000, 3'b000, 3'b000, "f_e10");
        ex(11, 3'b100, 3'b000, 3'b000, 3'b000, "f_e11");
        ex(12, 3'b100, 3'b100, 3'b100, 3'b000, "f_reenable");
        ch_enable = 3'b011;
        wr_do(2'd2, 8'd3, 1'b0);
        at(2);
        ch_enable = 3'b111;
        at(6);
        ch_enable = 3'b011;
        at(9);
        ch_enable = 3'b111;
        at(13);
        #2;
        Reset = 1'b0;
        ex(13, 3'b111, 3'b000, 3'b000, 3'b000, "f_async_reset");
        repeat (2) @(posedge inclk);
        #1;
        Reset = 1'b1;
        org = edge_n;
        ex(0, 3'b111, 3'b000, 3'b000, 3'b000, "r_e0");
        ex(3, 3'b111, 3'b000, 3'b000, 3'b000, "r_e3");
        ex(4, 3'b111, 3'b111, 3'b111, 3'b000, "r_e4");
        at(6);
        @(negedge inclk);
        #1;
        foreach (q[i]) begin
            total++;
            bad++;
            $display("FAIL %s never checked (edge %0d)", q[i].tag, q[i].e);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
